// File: rtl/mem_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter4_pkg
// Purpose  : Shared constants and state encoding for the 4-way memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter4_pkg;

    localparam int c_num_req = 4;
    localparam int c_idx_w   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter4_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational round-robin pick: first set request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mem_arbiter4_pkg::*;
(
    input  logic [c_num_req-1:0] req,
    input  logic [c_idx_w-1:0]   ptr,
    output logic                 any,
    output logic [c_idx_w-1:0]   idx,
    output logic [c_num_req-1:0] onehot
);

    logic [c_idx_w-1:0] w_cand;

    // Scan from the farthest offset down so the nearest candidate to ptr wins.
    always_comb begin
        any    = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int i = c_num_req - 1; i >= 0; i--) begin
            w_cand = ptr + c_idx_w'(i);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
        onehot = any ? (c_num_req'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter4
// Purpose  : 4-requester round-robin arbiter for a shared resource with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter4
    import mem_arbiter4_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
)
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [c_num_req-1:0] req,
    input  logic                 ack,
    output logic [c_num_req-1:0] gnt,
    output logic [c_idx_w-1:0]   sel,
    output logic                 valid,
    output logic [c_num_req-1:0] done,
    output logic                 err
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [c_num_req-1:0] r_gnt;
    logic [c_idx_w-1:0]   r_sel;
    logic [c_num_req-1:0] r_done;
    logic                 r_err;
    logic [c_idx_w-1:0]   r_ptr;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_any;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_num_req-1:0] w_onehot;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_onehot;
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                BUSY: begin
                    // Completion takes priority over a coincident timeout.
                    if (ack) begin
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                        r_ptr   <= r_sel + c_idx_w'(1);
                        r_state <= IDLE;
                    end else if (r_cnt == c_cnt_max) begin
                        r_gnt   <= '0;
                        r_err   <= 1'b1;
                        r_ptr   <= r_sel + c_idx_w'(1);
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = (r_state == BUSY);
    assign done  = r_done;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter4
// Purpose  : Self-checking bench for mem_arbiter4 with a transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter4;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] done;
    logic       err;

    typedef struct {
        int         idx;
        int         len;
        logic [3:0] done;
        logic       err;
    } txn_t;

    txn_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   run_len = 0;
    int   cur_sel = 0;

    mem_arbiter4 #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .ack   (ack),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: measures each grant and retires it against the scoreboard on done/err.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                run_len = 0;
            end else if (valid) begin
                run_len++;
                cur_sel = int'(sel);
                check("gnt_onehot", {28'd0, gnt}, {28'd0, 4'b0001 << sel});
            end else begin
                check("gnt_idle", {28'd0, gnt}, 32'd0);
                if (done != 4'b0000 || err) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", {27'd0, done, err}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("txn_sel",  cur_sel, e.idx);
                        check("txn_len",  run_len, e.len);
                        check("txn_done", {28'd0, done}, {28'd0, e.done});
                        check("txn_err",  {31'd0, err}, {31'd0, e.err});
                    end
                end
                run_len = 0;
            end
        end
    end

    // Called at #1 after an edge with the DUT in IDLE; returns the same way.
    // n_ack = 0 means never acknowledge (expect timeout).
    task automatic run_txn(input logic [3:0] rq, input logic [3:0] rq_busy, input int n_ack,
                           input int exp_idx, input int exp_len, input logic exp_err);
        txn_t       e;
        logic [3:0] oh;
        oh     = 4'b0001 << exp_idx;
        e.idx  = exp_idx;
        e.len  = exp_len;
        e.done = exp_err ? 4'b0000 : oh;
        e.err  = exp_err;
        sb.push_back(e);
        req = rq;
        @(posedge clk); #1;
        check("grant_valid", {31'd0, valid}, 32'd1);
        check("grant_gnt",   {28'd0, gnt}, {28'd0, oh});
        check("grant_sel",   {30'd0, sel}, exp_idx);
        req = rq_busy;
        if (n_ack > 0) begin
            repeat (n_ack - 1) begin
                @(posedge clk); #1;
            end
            ack = 1'b1;
            @(posedge clk); #1;
            ack = 1'b0;
        end else begin
            for (int i = 0; i < TIMEOUT + 8; i++) begin
                @(posedge clk); #1;
                if (!valid) break;
            end
        end
        check("txn_end_valid", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        req  = 4'b0000;
        ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",   {28'd0, gnt}, 32'd0);
        check("rst_sel",   {30'd0, sel}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_done",  {28'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single requester, ack on third BUSY cycle; req dropped mid-grant.
        run_txn(4'b0100, 4'b0000, 3, 2, 3, 1'b0);
        // ptr=3: skip and wrap to 0, then 1.
        run_txn(4'b0011, 4'b0011, 1, 0, 1, 1'b0);
        run_txn(4'b0011, 4'b0000, 1, 1, 1, 1'b0);

        // Reset in BUSY cycle 2: silent abort, outputs clear without an edge.
        req = 4'b0001;
        @(posedge clk); #1;
        req = 4'b0000;
        check("rstmid_busy", {31'd0, valid}, 32'd1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("rstmid_gnt",   {28'd0, gnt}, 32'd0);
        check("rstmid_sel",   {30'd0, sel}, 32'd0);
        check("rstmid_valid", {31'd0, valid}, 32'd0);
        check("rstmid_done",  {28'd0, done}, 32'd0);
        check("rstmid_err",   {31'd0, err}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, valid}, 32'd0);

        // Fairness from ptr=0 with all requesters held.
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, (k == 4) ? 4'b0000 : 4'b1111, 1, k % 4, 1, 1'b0);
        end

        // Timeout on requester 1, then next search starts at 2.
        run_txn(4'b0010, 4'b0000, 0, 1, TIMEOUT, 1'b1);
        run_txn(4'b0110, 4'b0000, 1, 2, 1, 1'b0);
        // Ack on the timeout cycle: completion wins.
        run_txn(4'b1000, 4'b0000, TIMEOUT, 3, TIMEOUT, 1'b0);

        // Ack in IDLE is ignored; sel retains last winner.
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("idle_ack_gnt",   {28'd0, gnt}, 32'd0);
        check("idle_ack_valid", {31'd0, valid}, 32'd0);
        check("idle_ack_sel",   {30'd0, sel}, 32'd3);
        check("idle_ack_done",  {28'd0, done}, 32'd0);
        check("idle_ack_err",   {31'd0, err}, 32'd0);

        // Other requesters toggling during a grant do not disturb it.
        run_txn(4'b0001, 4'b1110, 4, 0, 4, 1'b0);
        req = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
